// File: rtl/eth_phy_10g_rx_ber_monitor.sv
// -----------------------------------------------------------------------------
// eth_phy_10g_rx_ber_monitor
//
// 10GBASE-R receive BER monitor (Clause 49 style). Samples the aligned 2-bit
// sync header every cycle, counts invalid headers (00/11) inside a fixed-length
// window and raises o_rx_high_ber when BER_LIMIT invalid headers land in one
// window. The flag is released only after a complete test window ends below the
// limit. A separate saturating counter of invalid headers seen while locked is
// kept for status readout.
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset
//   i_rx_hdr         aligned sync header
//   i_rx_hdr_valid   i_rx_hdr carries a block this cycle
//   i_rx_block_lock  block lock from frame aligner
//   o_rx_high_ber    high BER flag
//   o_ber_count      saturating count of invalid headers seen while locked
//   o_window_done    one-cycle pulse one clock after each window ends
// -----------------------------------------------------------------------------
module eth_phy_10g_rx_ber_monitor #(
  parameter int HDR_WIDTH    = 2,
  parameter int TIMER_CYCLES = 19531,
  parameter int BER_LIMIT    = 16,
  parameter int COUNT_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [HDR_WIDTH-1:0]   i_rx_hdr,
  input  logic                   i_rx_hdr_valid,
  input  logic                   i_rx_block_lock,
  output logic                   o_rx_high_ber,
  output logic [COUNT_WIDTH-1:0] o_ber_count,
  output logic                   o_window_done
);

  localparam int TIMER_W = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(TIMER_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     TIMER_ONE  = TIMER_W'(1);
  localparam logic [4:0]             LIMIT      = 5'(BER_LIMIT);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    BER_MT_INIT = 2'd0,
    BER_TEST    = 2'd1,
    HI_BER      = 2'd2
  } ber_state_t;

  ber_state_t               r_state;
  ber_state_t               w_state_nxt;
  logic [TIMER_W-1:0]       r_timer;
  logic [TIMER_W-1:0]       w_timer_nxt;
  logic [4:0]               r_ber_cnt;
  logic [4:0]               w_ber_cnt_nxt;
  logic                     r_high_ber;
  logic                     w_high_ber_nxt;
  logic [COUNT_WIDTH-1:0]   r_ber_count;
  logic [COUNT_WIDTH-1:0]   w_ber_count_nxt;
  logic                     r_window_done;

  logic                     w_bad_sh;
  logic                     w_timer_done;
  logic [4:0]               w_ber_cnt_inc;
  logic                     w_limit_hit;

  assign w_bad_sh      = i_rx_hdr_valid & ((i_rx_hdr == '0) | (i_rx_hdr == '1));
  assign w_timer_done  = (r_state != BER_MT_INIT) && (r_timer == TIMER_LAST);
  assign w_ber_cnt_inc = r_ber_cnt + 5'd1;
  // >= rather than == so a window counter parked at the limit can never
  // step past it and miss a trigger.
  assign w_limit_hit   = w_bad_sh && (w_ber_cnt_inc >= LIMIT);

  always_comb begin
    w_state_nxt    = r_state;
    w_ber_cnt_nxt  = r_ber_cnt;
    w_high_ber_nxt = r_high_ber;
    w_timer_nxt    = w_timer_done ? '0 : r_timer + TIMER_ONE;

    unique case (r_state)
      BER_MT_INIT: begin
        w_timer_nxt    = '0;
        w_ber_cnt_nxt  = '0;
        w_high_ber_nxt = 1'b0;
        if (i_rx_block_lock) begin
          w_state_nxt = BER_TEST;
        end
      end
      BER_TEST: begin
        // Limit hit wins over a coincident window end.
        if (w_limit_hit) begin
          w_state_nxt    = HI_BER;
          w_high_ber_nxt = 1'b1;
          w_ber_cnt_nxt  = LIMIT;
        end else if (w_timer_done) begin
          w_high_ber_nxt = 1'b0;
          w_ber_cnt_nxt  = {4'd0, w_bad_sh};
        end else if (w_bad_sh) begin
          w_ber_cnt_nxt  = w_ber_cnt_inc;
        end
      end
      HI_BER: begin
        w_high_ber_nxt = 1'b1;
        if (w_timer_done) begin
          w_state_nxt   = BER_TEST;
          w_ber_cnt_nxt = {4'd0, w_bad_sh};
        end
      end
      default: begin
        w_state_nxt    = BER_MT_INIT;
        w_timer_nxt    = '0;
        w_ber_cnt_nxt  = '0;
        w_high_ber_nxt = 1'b0;
      end
    endcase

    // Lock loss overrides every transition; clearing the window here means
    // INIT is always entered with a zeroed timer and no stale window_done.
    if (!i_rx_block_lock) begin
      w_state_nxt    = BER_MT_INIT;
      w_timer_nxt    = '0;
      w_ber_cnt_nxt  = '0;
      w_high_ber_nxt = 1'b0;
    end

    w_ber_count_nxt = r_ber_count;
    if (i_rx_block_lock && w_bad_sh && (r_ber_count != CNT_MAX)) begin
      w_ber_count_nxt = r_ber_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= BER_MT_INIT;
      r_timer       <= '0;
      r_ber_cnt     <= '0;
      r_high_ber    <= 1'b0;
      r_ber_count   <= '0;
      r_window_done <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_ber_cnt     <= w_ber_cnt_nxt;
      r_high_ber    <= w_high_ber_nxt;
      r_ber_count   <= w_ber_count_nxt;
      r_window_done <= w_timer_done;
    end
  end

  assign o_rx_high_ber = r_high_ber;
  assign o_ber_count   = r_ber_count;
  assign o_window_done = r_window_done;

endmodule

// File: tb/tb_eth_phy_10g_rx_ber_monitor.sv
// -----------------------------------------------------------------------------
// tb_eth_phy_10g_rx_ber_monitor
//
// Directed scenarios plus randomized traffic for the BER monitor, compared
// cycle by cycle against a window-age based reference model.
// -----------------------------------------------------------------------------
module tb_eth_phy_10g_rx_ber_monitor;

  localparam int TC    = 64;
  localparam int LIMIT = 16;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [1:0]    i_rx_hdr;
  logic          i_rx_hdr_valid;
  logic          i_rx_block_lock;
  logic          o_rx_high_ber;
  logic [CW-1:0] o_ber_count;
  logic          o_window_done;

  eth_phy_10g_rx_ber_monitor #(
    .HDR_WIDTH    (2),
    .TIMER_CYCLES (TC),
    .BER_LIMIT    (LIMIT),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_rx_hdr        (i_rx_hdr),
    .i_rx_hdr_valid  (i_rx_hdr_valid),
    .i_rx_block_lock (i_rx_block_lock),
    .o_rx_high_ber   (o_rx_high_ber),
    .o_ber_count     (o_ber_count),
    .o_window_done   (o_window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: tracks whether a monitoring session is active, how many
  // cycles it has run (window end every TC cycles), bad headers in the current
  // window and whether the current window is a high-BER hold window.
  bit m_active;
  bit m_holding;
  int m_age;
  int m_win_bad;
  bit m_high;
  int m_total;
  bit m_wd;
  int since;

  task automatic model(input logic r, input logic [1:0] h, input logic v, input logic l);
    bit bad;
    bit last;
    bad = v && (h == 2'b00 || h == 2'b11);
    if (r) begin
      m_active = 0; m_holding = 0; m_age = 0; m_win_bad = 0;
      m_high = 0; m_total = 0; m_wd = 0;
    end else begin
      last = m_active && ((m_age % TC) == TC - 1);
      m_wd = last;
      if (l && bad && m_total < CMAX) m_total++;
      if (!l) begin
        m_active = 0; m_holding = 0; m_age = 0; m_win_bad = 0; m_high = 0;
      end else if (!m_active) begin
        m_active = 1; m_age = 0; m_win_bad = 0; m_high = 0;
      end else begin
        m_age++;
        if (!m_holding) begin
          if (bad && m_win_bad + 1 >= LIMIT) begin
            m_holding = 1; m_high = 1;
          end else if (last) begin
            m_high = 0; m_win_bad = bad ? 1 : 0;
          end else if (bad) begin
            m_win_bad++;
          end
        end else if (last) begin
          m_holding = 0; m_win_bad = bad ? 1 : 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] h, input logic v, input logic l);
    rst = r; i_rx_hdr = h; i_rx_hdr_valid = v; i_rx_block_lock = l;
    @(posedge clk);
    model(r, h, v, l);
    since++;
    #1;
    check_eq("high_ber", o_rx_high_ber, m_high);
    check_eq("ber_count", o_ber_count, m_total);
    check_eq("window_done", o_window_done, m_wd);
  endtask

  task automatic good();
    step(0, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 1, 1);
  endtask

  task automatic bad();
    step(0, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, 1, 1);
  endtask

  // Reset, then one locked cycle in INIT so the first window starts at since=1.
  task automatic relock();
    step(1, 2'b01, 1, 0);
    step(0, 2'b01, 1, 1);
    since = 0;
  endtask

  initial begin
    int pulses;
    int rate;
    rst = 1; i_rx_hdr = 2'b01; i_rx_hdr_valid = 1; i_rx_block_lock = 0;
    since = 0;
    model(1, 2'b01, 1, 0);

    // Reset state
    repeat (3) step(1, 2'b00, 1, 1);
    check_eq("rst_high", o_rx_high_ber, 0);
    check_eq("rst_count", o_ber_count, 0);
    check_eq("rst_wd", o_window_done, 0);

    // Three clean windows
    relock();
    pulses = 0;
    repeat (194) begin
      good();
      if (o_window_done) pulses++;
    end
    check_eq("clean_pulses", pulses, 3);
    check_eq("clean_high", o_rx_high_ber, 0);
    check_eq("clean_count", o_ber_count, 0);

    // 16 bad headers spread over one window
    relock();
    for (int i = 0; i < 16; i++) begin
      bad();
      if (i == 14) check_eq("hi_before16", o_rx_high_ber, 0);
      if (i == 15) begin
        check_eq("hi_after16", o_rx_high_ber, 1);
        check_eq("count16", o_ber_count, 16);
      end
      good();
      good();
    end

    // Flag holds through the HI window and the next clean test window
    while (since < 127) good();
    check_eq("hi_hold", o_rx_high_ber, 1);
    good();
    check_eq("hi_release", o_rx_high_ber, 0);

    // 15 bad per window across a boundary
    relock();
    repeat (15) bad();
    while (since < 64) good();
    repeat (15) bad();
    while (since < 140) good();
    check_eq("split15_high", o_rx_high_ber, 0);
    check_eq("split15_count", o_ber_count, 30);

    // Bad header coincident with window end, ber_cnt=15 -> high BER
    relock();
    repeat (15) bad();
    while (since < 63) good();
    bad();
    check_eq("prio_hi", o_rx_high_ber, 1);

    // Coincident with window end, ber_cnt=3 -> new window starts at 1
    relock();
    repeat (3) bad();
    while (since < 63) good();
    bad();
    check_eq("prio_lo", o_rx_high_ber, 0);
    repeat (14) bad();
    check_eq("newwin15", o_rx_high_ber, 0);
    bad();
    check_eq("newwin16", o_rx_high_ber, 1);

    // Lock loss while high
    step(0, 2'b00, 1, 0);
    check_eq("lockloss_high", o_rx_high_ber, 0);
    check_eq("lockloss_count", o_ber_count, 19);
    repeat (5) step(0, 2'b00, 1, 0);
    check_eq("unlocked_count", o_ber_count, 19);

    // Saturation and reset
    relock();
    repeat (70) bad();
    check_eq("sat_count", o_ber_count, CMAX);
    step(1, 2'b01, 1, 1);
    check_eq("sat_rst", o_ber_count, 0);

    // Randomized traffic
    rate = 0;
    for (int c = 0; c < 1500; c++) begin
      logic r, v, l, b;
      if (c % 128 == 0) rate = $urandom_range(0, 3) * 20;
      r = ($urandom_range(0, 399) == 0);
      l = ($urandom_range(0, 299) != 0);
      v = ($urandom_range(0, 9) != 0);
      b = ($urandom_range(0, 99) < rate);
      if (b) step(r, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, v, l);
      else   step(r, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, v, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
